bcd_scan_7seg: RTL and testbench



---
 rtl/bcd_scan_7seg.sv | 100 ++++++++++
 tb/tb_bcd_scan_7seg.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bcd_scan_7seg.sv
// bcd_scan_7seg: latches packed BCD once it has been stable and multiplexes three digits onto one 7-segment bus
// Ports: clk, rst (sync, active-high); bdc[11:0] packed BCD {hundreds, tens, units};
//        seg[6:0] {g..a} active-low; an[2:0] {hundreds, tens, units} active-low;
//        upd one-cycle pulse when the latched value changes; err high while a latched nibble exceeds 9.
// Optional macro LZB_EN: leading-zero blanking of the hundreds and tens slots.
module bcd_scan_7seg #(
    parameter int SCAN_DIV   = 1000,
    parameter int STABLE_CYC = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bdc,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic        upd,
    output logic        err
);
    localparam int SW = $clog2(STABLE_CYC + 1);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC);
    localparam logic [SW-1:0] STAB_HIT = SW'(STABLE_CYC - 1);
    localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);

    logic [11:0]   bdc_q, disp_q, disp_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          upd_q, upd_d, err_q, err_d;
    logic          same, latch, wrap;
    logic [3:0]    nib;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            default: dec = 7'h06;
        endcase
    endfunction

    always_comb begin
        same   = bdc == bdc_q;
        // a mismatch on the latch cycle wins, so the latch also requires same
        latch  = same && stab_q == STAB_HIT;
        stab_d = !same ? '0 : (stab_q != STAB_MAX ? stab_q + 1'b1 : stab_q);
        disp_d = latch ? bdc : disp_q;
        upd_d  = latch && bdc != disp_q;
        err_d  = disp_q[11:8] > 4'd9 || disp_q[7:4] > 4'd9 || disp_q[3:0] > 4'd9;
        wrap   = pre_q == PRE_MAX;
        pre_d  = wrap ? '0 : pre_q + 1'b1;
        idx_d  = wrap ? (idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1) : idx_q;
        nib    = idx_q == 2'd2 ? disp_q[11:8] : idx_q == 2'd1 ? disp_q[7:4] : disp_q[3:0];
`ifdef LZB_EN
        an_d   = (idx_q == 2'd2 && disp_q[11:8] == 4'd0) || (idx_q == 2'd1 && disp_q[11:4] == 8'd0) ? 3'b111 :
                 idx_q == 2'd2 ? 3'b011 : idx_q == 2'd1 ? 3'b101 : 3'b110;
        seg_d  = an_d == 3'b111 ? 7'h7F : dec(nib);
`else
        an_d   = idx_q == 2'd2 ? 3'b011 : idx_q == 2'd1 ? 3'b101 : 3'b110;
        seg_d  = dec(nib);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bdc_q  <= '0;
            stab_q <= '0;
            disp_q <= '0;
            pre_q  <= '0;
            idx_q  <= '0;
            seg_q  <= 7'h7F;
            an_q   <= 3'b111;
            upd_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            bdc_q  <= bdc;
            stab_q <= stab_d;
            disp_q <= disp_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            upd_q  <= upd_d;
            err_q  <= err_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign upd = upd_q;
    assign err = err_q;
endmodule

// File: tb/tb_bcd_scan_7seg.sv
// tb_bcd_scan_7seg: randomized and directed checks of bcd_scan_7seg against a run-length/frame-count reference model
module tb_bcd_scan_7seg;
    localparam int SCAN_DIV   = 4;
    localparam int STABLE_CYC = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] bdc = 12'h456;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        upd;
    logic        err;

    int n_chk = 0;
    int n_err = 0;
    int upd_seen = 0;

    logic [11:0] m_disp = '0;
    logic [11:0] run_val = '0;
    int          run = 1;
    int          cyc = 0;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    bcd_scan_7seg #(.SCAN_DIV(SCAN_DIV), .STABLE_CYC(STABLE_CYC)) dut (
        .clk(clk), .rst(rst), .bdc(bdc), .seg(seg), .an(an), .upd(upd), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_an", 32'(an), 32'h7);
            chk("rst_upd", 32'(upd), 32'h0);
            chk("rst_err", 32'(err), 32'h0);
        end
        m_disp  = '0;
        run_val = '0;
        run     = 1;
        cyc     = 0;
        rst     = 1'b0;
    endtask

    // Model: a value latches when it has been seen on STABLE_CYC+1 consecutive edges
    // (the reset-time register value counts as one); the lit digit is (cycles since reset / SCAN_DIV) mod 3.
    task automatic tick(input logic [11:0] v);
        int d;
        logic [3:0] nb;
        logic [6:0] es;
        logic [2:0] ea;
        logic eu, ee;
        bdc = v;
        @(posedge clk);
        d  = (cyc / SCAN_DIV) % 3;
        nb = 4'(m_disp >> (4 * d));
        ea = 3'b111 ^ 3'(1 << d);
        es = seg_tab[nb];
`ifdef LZB_EN
        if ((d == 2 && m_disp[11:8] == 4'd0) || (d == 1 && m_disp[11:4] == 8'd0)) begin
            ea = 3'b111;
            es = 7'h7F;
        end
`endif
        ee = m_disp[11:8] > 9 || m_disp[7:4] > 9 || m_disp[3:0] > 9;
        if (v == run_val) run++;
        else begin
            run_val = v;
            run = 1;
        end
        eu = 1'b0;
        if (run == STABLE_CYC + 1) begin
            eu = v != m_disp;
            m_disp = v;
        end
        cyc++;
        #1;
        chk("seg", 32'(seg), 32'(es));
        chk("an", 32'(an), 32'(ea));
        chk("upd", 32'(upd), 32'(eu));
        chk("err", 32'(err), 32'(ee));
        if (upd) upd_seen++;
    endtask

    task automatic hold(input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) tick(v);
    endtask

    initial begin
        logic [11:0] v, prev;
        do_reset(3);
        upd_seen = 0;
        hold(12'h123, 40);
        chk("upd_123_once", 32'(upd_seen), 32'd1);

        upd_seen = 0;
        prev = 12'h123;
        for (int k = 0; k < 20; k++) begin
            v = 12'($urandom);
            if (v == prev) v = ~v;
            hold(v, 5);
            prev = v;
        end
        chk("chatter_upd", 32'(upd_seen), 32'd0);
        hold(12'h255, 20);
        chk("upd_255_once", 32'(upd_seen), 32'd1);

        hold(12'h1A5, 20);
        chk("err_1a5", 32'(err), 32'd1);
        hold(12'h105, 20);
        chk("err_105", 32'(err), 32'd0);

        hold(12'h007, 30);

        for (int k = 0; k < 30; k++) begin
            v = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            hold(v, $urandom_range(1, 25));
        end

        hold(12'h987, 14);
        while (cyc % (3 * SCAN_DIV) != 2 * SCAN_DIV + 2) tick(12'h987);
        do_reset(1);
        hold(12'h987, 2 * 3 * SCAN_DIV);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
